// File: rtl/tpu_pkg.sv
// Shared TPU definitions: master FSM encoding, default timing knobs, TPU address map.
package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    BUS   = 3'd2,
    GAP   = 3'd3,
    FIN   = 3'd4
  } tpu_state_e;

  localparam int          TPU_ADDR_STEP   = 1;
  localparam int          TPU_TIMEOUT     = 15;
  localparam logic [23:0] TPU_BASE        = 24'h300000;
  localparam int          TPU_NUM_WEIGHTS = 9;

endpackage

// File: rtl/wb_tpu_master_if.sv
// Command/data stream plus Wishbone classic initiator bundle for the TPU master.
interface wb_tpu_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, wdata_valid, wdata, wbm_ack_i, wbm_dat_i,
    output cmd_ready, wdata_ready, rdata_valid, rdata, busy, done, err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_len, wdata_valid, wdata, wbm_ack_i, wbm_dat_i,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, busy, done, err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_tpu_master.sv
// Wishbone classic burst-by-beat master: one command expands into len single-beat
// cycles, each separated by an idle GAP cycle, with a per-beat ack timeout.
module wb_tpu_master
  import tpu_pkg::*;
#(
  parameter int ADDR_STEP = TPU_ADDR_STEP,
  parameter int TIMEOUT   = TPU_TIMEOUT
) (
  input  logic caravel_wb_clk_i,
  input  logic caravel_wb_rst_i,
  wb_tpu_master_if.master bus
);

  // Counter only has to reach TIMEOUT-1.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  tpu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvld_q, rvld_d;

  // Next-state and datapath updates; timeout counter is held at zero outside BUS
  // so every entry to BUS starts a fresh wait window.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    tmo_d   = (state_q == BUS) ? tmo_q : '0;
    err_d   = err_q;
    rdata_d = rdata_q;
    rvld_d  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.cmd_valid) begin
        we_d    = bus.cmd_we;
        adr_d   = bus.cmd_addr;
        cnt_d   = (bus.cmd_len == 4'd0) ? 4'd1 : bus.cmd_len;
        err_d   = 1'b0;
        state_d = bus.cmd_we ? FETCH : BUS;
      end
      FETCH: if (bus.wdata_valid) begin
        dat_d   = bus.wdata;
        state_d = BUS;
      end
      BUS: begin
        if (bus.wbm_ack_i) begin
          if (!we_q) begin
            rdata_d = bus.wbm_dat_i;
            rvld_d  = 1'b1;
          end
          cnt_d   = cnt_q - 4'd1;
          adr_d   = adr_q + 32'(ADDR_STEP);
          state_d = GAP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // Give up: remaining beats are dropped, err rides along with done.
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GAP:  state_d = (cnt_q != 4'd0) ? (we_q ? FETCH : BUS) : FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge caravel_wb_clk_i) begin
    if (caravel_wb_rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
    end
  end

  // Bus strobes follow the state directly, so reset drops them on the next edge.
  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.wdata_ready = (state_q == FETCH);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == FIN);
  assign bus.err         = (state_q == FIN) && err_q;
  assign bus.rdata_valid = rvld_q;
  assign bus.rdata       = rdata_q;
  assign bus.wbm_cyc_o   = (state_q == BUS);
  assign bus.wbm_stb_o   = (state_q == BUS);
  assign bus.wbm_we_o    = we_q;
  assign bus.wbm_sel_o   = (state_q == BUS) ? 4'hF : 4'h0;
  assign bus.wbm_adr_o   = adr_q;
  assign bus.wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_tpu_master.sv
// Directed bench for wb_tpu_master: command table plus FETCH-stall, mid-burst
// reset and back-to-back command sequences, against a 1-cycle-ack responder.
module tb_wb_tpu_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_tpu_master_if bus_if ();

  wb_tpu_master #(.ADDR_STEP(1), .TIMEOUT(15)) dut (
    .caravel_wb_clk_i(clk),
    .caravel_wb_rst_i(rst),
    .bus(bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Responder: acks one cycle after stb, never two cycles in a row.
  logic ack_q;
  bit   ack_en    = 1'b1;
  bit   ack_force = 1'b0;

  function automatic logic [31:0] rsp_word(input logic [7:0] idx);
    if (idx == 8'd3)      return 32'h00AABBCC;
    else if (idx == 8'd4) return 32'h00112233;
    else                  return {24'hA50000, idx};
  endfunction

  always @(posedge clk) begin
    if (rst) ack_q <= 1'b0;
    else     ack_q <= ack_en && bus_if.wbm_cyc_o && bus_if.wbm_stb_o && !ack_q;
  end
  assign bus_if.wbm_ack_i = ack_q | ack_force;
  assign bus_if.wbm_dat_i = rsp_word(bus_if.wbm_adr_o[7:0]);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  len;
    bit          ack_en;
    int          exp_beats;
    bit          exp_err;
    int          exp_lat;
    int          exp_stb;
  } vec_t;

  // Run one command from the table, observing every cycle at the negedge.
  task automatic run_vec(input int id, input vec_t v);
    int lat, stb_cyc, bad, wr_idx;
    bit prev_ack, prev_stb, got_done, err_at_done;
    logic [31:0] prev_adr;
    logic [31:0] badr[$], bdat[$], rd[$];
    string tag;
    tag = $sformatf("v%0d", id);
    lat = 0; stb_cyc = 0; bad = 0; wr_idx = 0;
    prev_ack = 0; prev_stb = 0; got_done = 0; err_at_done = 0; prev_adr = '0;
    ack_en = v.ack_en;
    @(negedge clk);
    bus_if.cmd_we = v.we; bus_if.cmd_addr = v.addr; bus_if.cmd_len = v.len;
    bus_if.cmd_valid = 1'b1; bus_if.wdata_valid = v.we;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    lat = 1;
    while (lat < 300) begin
      if (bus_if.wdata_ready) begin
        bus_if.wdata = 32'(wr_idx + 1);
        wr_idx++;
      end
      if (bus_if.wbm_stb_o) stb_cyc++;
      if (prev_ack && bus_if.wbm_stb_o) bad++;
      if (bus_if.wbm_cyc_o != bus_if.wbm_stb_o) bad++;
      if (bus_if.wbm_stb_o && (bus_if.wbm_sel_o != 4'hF || bus_if.wbm_we_o != v.we)) bad++;
      if (prev_stb && bus_if.wbm_stb_o && bus_if.wbm_adr_o != prev_adr) bad++;
      prev_stb = bus_if.wbm_stb_o;
      prev_adr = bus_if.wbm_adr_o;
      prev_ack = bus_if.wbm_stb_o && bus_if.wbm_ack_i;
      if (prev_ack) begin
        badr.push_back(bus_if.wbm_adr_o);
        bdat.push_back(bus_if.wbm_dat_o);
      end
      if (bus_if.rdata_valid) rd.push_back(bus_if.rdata);
      if (bus_if.done) begin
        got_done = 1; err_at_done = bus_if.err;
        break;
      end
      @(negedge clk);
      lat++;
    end
    bus_if.wdata_valid = 1'b0;
    chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, "_err"}, 32'(err_at_done), 32'(v.exp_err));
    chk({tag, "_beats"}, 32'(badr.size()), 32'(v.exp_beats));
    chk({tag, "_stb_cycles"}, 32'(stb_cyc), 32'(v.exp_stb));
    chk({tag, "_protocol"}, 32'(bad), 32'd0);
    chk({tag, "_rdata_cnt"}, 32'(rd.size()), v.we ? 32'd0 : 32'(v.exp_beats));
    for (int i = 0; i < badr.size(); i++) begin
      chk($sformatf("%s_adr%0d", tag, i), badr[i], v.addr + 32'(i));
      if (v.we) chk($sformatf("%s_wdat%0d", tag, i), bdat[i], 32'(i + 1));
    end
    for (int i = 0; i < rd.size(); i++)
      chk($sformatf("%s_rdat%0d", tag, i), rd[i], rsp_word(8'(v.addr + 32'(i))));
    @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(bus_if.busy), 32'd0);
    chk({tag, "_idle_ready"}, 32'(bus_if.cmd_ready), 32'd1);
    chk({tag, "_idle_done"}, 32'(bus_if.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int acks, cyc_n, accept_cyc, done_cyc, bad, beats;
    logic [31:0] dat_before;

    vecs[0] = '{1'b1, 32'h30000000, 4'd9, 1'b1, 9, 1'b0, 37, 18};
    vecs[1] = '{1'b0, 32'h30000003, 4'd2, 1'b1, 2, 1'b0,  7,  4};
    vecs[2] = '{1'b0, 32'h30000040, 4'd0, 1'b1, 1, 1'b0,  4,  2};
    vecs[3] = '{1'b0, 32'h30000050, 4'd4, 1'b0, 0, 1'b1, 16, 15};
    vecs[4] = '{1'b0, 32'hFFFFFFFF, 4'd3, 1'b1, 3, 1'b0, 10,  6};
    vecs[5] = '{1'b1, 32'h30000005, 4'd1, 1'b1, 1, 1'b0,  5,  2};

    bus_if.cmd_valid = 0; bus_if.cmd_we = 0; bus_if.cmd_addr = '0; bus_if.cmd_len = '0;
    bus_if.wdata_valid = 0; bus_if.wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_cyc_stb", {30'd0, bus_if.wbm_cyc_o, bus_if.wbm_stb_o}, 32'd0);
    chk("rst_sel", 32'(bus_if.wbm_sel_o), 32'd0);
    chk("rst_we", 32'(bus_if.wbm_we_o), 32'd0);
    chk("rst_adr", bus_if.wbm_adr_o, 32'd0);
    chk("rst_dat", bus_if.wbm_dat_o, 32'd0);
    chk("rst_rdata", bus_if.rdata, 32'd0);
    chk("rst_pulses", {29'd0, bus_if.rdata_valid, bus_if.done, bus_if.err}, 32'd0);
    chk("rst_wdata_ready", 32'(bus_if.wdata_ready), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);
    ack_en = 1'b1;

    // Idle wdata and stray acks are ignored; FETCH stalls without touching the bus.
    dat_before = bus_if.wbm_dat_o;
    bus_if.wdata = 32'hDEADBEEF; bus_if.wdata_valid = 1'b1; ack_force = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus_if.busy || bus_if.rdata_valid || bus_if.done || bus_if.wbm_stb_o) bad++;
    end
    chk("idle_stray_ack", 32'(bad), 32'd0);
    chk("idle_wdata_not_taken", bus_if.wbm_dat_o, dat_before);
    bus_if.wdata_valid = 1'b0;
    bus_if.cmd_we = 1'b1; bus_if.cmd_addr = 32'h30000020; bus_if.cmd_len = 4'd1;
    bus_if.cmd_valid = 1'b1;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    bad = 0;
    repeat (5) begin
      if (!bus_if.wdata_ready || bus_if.wbm_cyc_o || bus_if.wbm_stb_o || bus_if.rdata_valid) bad++;
      @(negedge clk);
    end
    chk("fetch_stall_bus_idle", 32'(bad), 32'd0);
    ack_force = 1'b0;
    bus_if.wdata = 32'h0BADF00D; bus_if.wdata_valid = 1'b1;
    @(negedge clk);
    bus_if.wdata_valid = 1'b0;
    chk("fetch_release_stb", 32'(bus_if.wbm_stb_o), 32'd1);
    chk("fetch_release_dat", bus_if.wbm_dat_o, 32'h0BADF00D);
    chk("fetch_release_adr", bus_if.wbm_adr_o, 32'h30000020);
    cyc_n = 0;
    while (!bus_if.done && cyc_n < 50) begin @(negedge clk); cyc_n++; end
    chk("fetch_release_done", 32'(bus_if.done), 32'd1);
    @(negedge clk);

    // Reset during the BUS phase of beat 3 of 9.
    bus_if.cmd_we = 1'b0; bus_if.cmd_addr = 32'h30000000; bus_if.cmd_len = 4'd9;
    bus_if.cmd_valid = 1'b1;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    acks = 0; cyc_n = 0;
    while (!(acks == 2 && bus_if.wbm_stb_o) && cyc_n < 50) begin
      if (bus_if.wbm_stb_o && bus_if.wbm_ack_i) acks++;
      @(negedge clk); cyc_n++;
    end
    chk("mid_rst_reached_beat3", 32'(acks), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cyc_stb", {30'd0, bus_if.wbm_cyc_o, bus_if.wbm_stb_o}, 32'd0);
    chk("mid_rst_idle", {30'd0, bus_if.busy, bus_if.cmd_ready}, 32'd1);
    chk("mid_rst_no_done", {30'd0, bus_if.done, bus_if.err}, 32'd0);
    rst = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_if.done || bus_if.err || bus_if.busy || bus_if.wbm_stb_o) bad++;
    end
    chk("mid_rst_quiet_after", 32'(bad), 32'd0);

    // cmd_valid held through a len=0 read: second accept only after FIN.
    bus_if.cmd_we = 1'b0; bus_if.cmd_addr = 32'h30000060; bus_if.cmd_len = 4'd0;
    bus_if.cmd_valid = 1'b1;
    @(negedge clk);
    cyc_n = 1; accept_cyc = 0; done_cyc = 0; bad = 0; beats = 0;
    while (cyc_n < 50) begin
      if (bus_if.busy && bus_if.cmd_ready) bad++;
      if (bus_if.wbm_stb_o && bus_if.wbm_ack_i) beats++;
      if (bus_if.done) done_cyc = cyc_n;
      if (bus_if.cmd_ready) begin accept_cyc = cyc_n; break; end
      @(negedge clk); cyc_n++;
    end
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    chk("hold_ready_low_busy", 32'(bad), 32'd0);
    chk("hold_len0_beats", 32'(beats), 32'd1);
    chk("hold_done_cycle", 32'(done_cyc), 32'd4);
    chk("hold_accept_cycle", 32'(accept_cyc), 32'd5);
    chk("hold_second_busy", 32'(bus_if.busy), 32'd1);
    cyc_n = 0;
    while (!bus_if.done && cyc_n < 50) begin @(negedge clk); cyc_n++; end
    chk("hold_second_done", 32'(bus_if.done), 32'd1);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
